dm_access_ctrl: RTL and testbench

Load/store access controller that sits between the pipeline memory stage and the word-organised data memory. It accepts byte-addressed RISC-V load/store requests over a valid/ready handshake and drives the memory's MemRead/MemWrite/address/write-data port. Loads (lb/lh/lw/lbu/lhu) get sign- or zero-extension. Sub-word stores (sb/sh) are done as a read-modify-write of the containing word, and misaligned or illegal accesses are flagged as errors without touching memory.

---
 rtl/dm_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - load/store access controller for a word-organised data memory
// Accepts byte-addressed RISC-V loads/stores, extends load data, performs
// sub-word stores as read-modify-write, and flags misaligned/illegal accesses.
module dm_access_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  input  logic [DATA_W-1:0]     rd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            r_state;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lane;
  logic [DM_ADDRESS-1:0] r_a;
  logic [DATA_W-1:0]     r_wd;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;

  logic                  w_req_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_W-1:0]     w_load;
  logic [DATA_W-1:0]     w_merged;
  logic                  w_unused;

  // Upper address bits alias onto the memory and are deliberately dropped.
  assign w_unused = ^req_addr[31:DM_ADDRESS+2];

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign a          = r_a;
  assign wd         = r_wd;
  // Gating with reset makes the enables fall in the same instant reset rises.
  assign MemRead    = (r_state == S_READ)  & ~reset;
  assign MemWrite   = (r_state == S_WRITE) & ~reset;

  // Classify the incoming request: undefined funct3, unsigned stores, misalignment.
  always_comb begin
    w_req_err = 1'b0;
    case (req_funct3)
      3'b000:  w_req_err = 1'b0;
      3'b001:  w_req_err = req_addr[0];
      3'b010:  w_req_err = (req_addr[1:0] != 2'b00);
      3'b100:  w_req_err = req_we;
      3'b101:  w_req_err = req_we | req_addr[0];
      default: w_req_err = 1'b1;
    endcase
  end

  // Select the addressed byte and halfword out of the word being read.
  always_comb begin
    w_byte = rd[7:0];
    case (r_lane)
      2'd0:    w_byte = rd[7:0];
      2'd1:    w_byte = rd[15:8];
      2'd2:    w_byte = rd[23:16];
      default: w_byte = rd[31:24];
    endcase
    w_half = r_lane[1] ? rd[31:16] : rd[15:0];
  end

  // Sign- or zero-extend the selected lane according to the load type.
  always_comb begin
    w_load = '0;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = rd;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = '0;
    endcase
  end

  // Overlay sub-word store data onto the word just read; r_wd still holds store data here.
  always_comb begin
    w_merged = rd;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_lane)
        2'd0:    w_merged[7:0]   = r_wd[7:0];
        2'd1:    w_merged[15:8]  = r_wd[7:0];
        2'd2:    w_merged[23:16] = r_wd[7:0];
        default: w_merged[31:24] = r_wd[7:0];
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wd[15:0];
    end else begin
      w_merged[15:0] = r_wd[15:0];
    end
  end

  // Request sequencing: accept, optional read, optional write, then hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_lane   <= 2'd0;
      r_a      <= '0;
      r_wd     <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_lane   <= req_addr[1:0];
            r_a      <= req_addr[DM_ADDRESS+1:2];
            r_wd     <= req_wdata;
            r_rdata  <= '0;
            r_err    <= w_req_err;
            if (w_req_err)
              r_state <= S_RESP;
            else if (req_we && (req_funct3 == 3'b010))
              r_state <= S_WRITE;
            else
              r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_we) begin
            r_wd    <= w_merged;
            r_state <= S_WRITE;
          end else begin
            r_rdata <= w_load;
            r_state <= S_RESP;
          end
        end
        S_WRITE: r_state <= S_RESP;
        default: begin
          if (resp_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - self-checking bench for dm_access_ctrl
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];

  int errors = 0;
  int checks = 0;

  dm_access_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .rd(rd)
  );

  always #5 clk = ~clk;

  assign rd = mem[a];
  always @(posedge clk) if (MemWrite) mem[a] <= wd;

  // Reference: plain byte-lane arithmetic on a separate memory image.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] exp_rdata,
                       output logic exp_err, output int exp_edges, output int exp_nrd,
                       output int exp_nwr);
    int k, h, idx;
    logic [31:0] w, b, hv;
    k = int'(addr[1:0]);
    h = int'(addr[1]);
    idx = int'(addr[10:2]);
    w = ref_mem[idx];
    b = (w >> (8 * k)) & 32'hFF;
    hv = (w >> (16 * h)) & 32'hFFFF;
    exp_err = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5)) ||
              ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr[1:0] != 0);
    exp_rdata = 0; exp_nrd = 0; exp_nwr = 0; exp_edges = 1;
    if (!exp_err) begin
      if (!we) begin
        exp_edges = 2; exp_nrd = 1;
        case (f3)
          3'd0: exp_rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
          3'd1: exp_rdata = (hv >= 32768) ? (hv | 32'hFFFF_0000) : hv;
          3'd2: exp_rdata = w;
          3'd4: exp_rdata = b;
          default: exp_rdata = hv;
        endcase
      end else if (f3 == 2) begin
        exp_edges = 2; exp_nwr = 1;
        ref_mem[idx] = wdata;
      end else begin
        exp_edges = 3; exp_nrd = 1; exp_nwr = 1;
        if (f3 == 0)
          ref_mem[idx] = (w & ~(32'hFF << (8 * k))) | ((wdata & 32'hFF) << (8 * k));
        else
          ref_mem[idx] = (w & ~(32'hFFFF << (16 * h))) | ((wdata & 32'hFFFF) << (16 * h));
      end
    end
  endtask

  // Drive one request from IDLE and follow it to the response handshake.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                        output int edges, output int nrd, output int nwr,
                        output logic [8:0] wa, output logic both);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    edges = 1; nrd = 0; nwr = 0; wa = 0; both = 1'b0;
    while (!resp_valid && edges < 12) begin
      if (MemRead) nrd++;
      if (MemWrite) begin nwr++; wa = a; end
      if (MemRead && MemWrite) both = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    rdata = resp_rdata; err = resp_err;
    if (MemRead || MemWrite) both = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_valid, resp_err, MemRead, MemWrite});
    end
    checks++;
    if ({resp_rdata, a, wd} !== 73'd0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h a=%h wd=%h want all 0", resp_rdata, a, wd);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    logic [31:0] rdata, er; logic err, me, both; logic [8:0] wa;
    int edges, nrd, nwr, ee, en, ew;
    logic [31:0] addrs [4];
    logic [2:0]  f3s   [4];
    logic [31:0] wants [4];
    mem[3] = 32'h8877_6655; ref_mem[3] = 32'h8877_6655;
    addrs = '{32'h0F, 32'h0F, 32'h0C, 32'h0E};
    f3s   = '{3'd0, 3'd4, 3'd1, 3'd0};
    wants = '{32'hFFFF_FF88, 32'h0000_0088, 32'h0000_6655, 32'h0000_0077};
    for (int i = 0; i < 4; i++) begin
      model(1'b0, f3s[i], addrs[i], 32'd0, er, me, ee, en, ew);
      do_req(1'b0, f3s[i], addrs[i], 32'd0, rdata, err, edges, nrd, nwr, wa, both);
      checks++;
      if (rdata !== wants[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL load_data[%0d]: got %h err=%b want %h err=0", i, rdata, err, wants[i]);
      end
      checks++;
      if (edges != 2 || nrd != 1 || nwr != 0 || both) begin
        errors++;
        $display("FAIL load_timing[%0d]: edges=%0d rd=%0d wr=%0d want 2/1/0", i, edges, nrd, nwr);
      end
    end
  endtask

  task automatic test_sw;
    logic [31:0] rdata, er; logic err, me, both; logic [8:0] wa;
    int edges, nrd, nwr, ee, en, ew;
    model(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, er, me, ee, en, ew);
    do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rdata, err, edges, nrd, nwr, wa, both);
    checks++;
    if (edges != 2 || nrd != 0 || nwr != 1 || wa !== 9'd4 || err !== 1'b0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL sw_cycle: edges=%0d rd=%0d wr=%0d a=%0d err=%b want 2/0/1/4/0", edges, nrd, nwr, wa, err);
    end
    model(1'b0, 3'd2, 32'h10, 32'd0, er, me, ee, en, ew);
    do_req(1'b0, 3'd2, 32'h10, 32'd0, rdata, err, edges, nrd, nwr, wa, both);
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_readback: got %h want deadbeef", rdata);
    end
  endtask

  task automatic test_subword;
    logic [31:0] rdata, er; logic err, me, both; logic [8:0] wa;
    int edges, nrd, nwr, ee, en, ew;
    mem[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
    model(1'b1, 3'd0, 32'h15, 32'h0000_00AB, er, me, ee, en, ew);
    do_req(1'b1, 3'd0, 32'h15, 32'h0000_00AB, rdata, err, edges, nrd, nwr, wa, both);
    checks++;
    if (mem[5] !== 32'h1122_AB44 || edges != 3 || nrd != 1 || nwr != 1 || both) begin
      errors++;
      $display("FAIL sb_merge: mem=%h edges=%0d rd=%0d wr=%0d want 1122ab44/3/1/1", mem[5], edges, nrd, nwr);
    end
    model(1'b1, 3'd1, 32'h16, 32'h1234_CDEF, er, me, ee, en, ew);
    do_req(1'b1, 3'd1, 32'h16, 32'h1234_CDEF, rdata, err, edges, nrd, nwr, wa, both);
    checks++;
    if (mem[5] !== 32'hCDEF_AB44 || edges != 3 || nrd != 1 || nwr != 1 || both) begin
      errors++;
      $display("FAIL sh_merge: mem=%h edges=%0d rd=%0d wr=%0d want cdefab44/3/1/1", mem[5], edges, nrd, nwr);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rdata, er; logic err, me, both; logic [8:0] wa;
    int edges, nrd, nwr, ee, en, ew;
    logic        wes   [4];
    logic [2:0]  f3s   [4];
    logic [31:0] addrs [4];
    wes   = '{1'b0, 1'b1, 1'b0, 1'b1};
    f3s   = '{3'd2, 3'd1, 3'd3, 3'd4};
    addrs = '{32'h02, 32'h03, 32'h00, 32'h08};
    for (int i = 0; i < 4; i++) begin
      model(wes[i], f3s[i], addrs[i], 32'hFFFF_FFFF, er, me, ee, en, ew);
      do_req(wes[i], f3s[i], addrs[i], 32'hFFFF_FFFF, rdata, err, edges, nrd, nwr, wa, both);
      checks++;
      if (err !== 1'b1 || rdata !== 32'd0 || edges != 1 || nrd != 0 || nwr != 0 || both) begin
        errors++;
        $display("FAIL err_case[%0d]: err=%b rdata=%h edges=%0d rd=%0d wr=%0d want 1/0/1/0/0",
                 i, err, rdata, edges, nrd, nwr);
      end
    end
  endtask

  task automatic test_stall;
    int n;
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0C; req_wdata = 0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0C; req_wdata = 32'h5555_AAAA;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h8877_6655 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b rdata=%h err=%b ready=%b want 1/88776655/0/0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem[3] !== ref_mem[3]) begin
      errors++;
      $display("FAIL stall_release: ready=%b valid=%b mem3=%h want 1/0/%h", req_ready, resp_valid, mem[3], ref_mem[3]);
    end
  endtask

  task automatic test_reset_mid;
    mem[7] = 32'h0102_0304; ref_mem[7] = 32'h0102_0304;
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h1C; req_wdata = 32'hFF;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (MemRead !== 1'b1) begin
      errors++;
      $display("FAIL rmid_read: MemRead=%b want 1", MemRead);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (MemRead !== 1'b0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL rmid_drop: MemRead=%b MemWrite=%b want 0/0", MemRead, MemWrite);
    end
    @(posedge clk); #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b10000 ||
        {resp_rdata, a, wd} !== 73'd0 || mem[7] !== 32'h0102_0304) begin
      errors++;
      $display("FAIL rmid_state: ctrl=%b rdata=%h a=%h wd=%h mem7=%h want 10000/0/0/0/01020304",
               {req_ready, resp_valid, resp_err, MemRead, MemWrite}, resp_rdata, a, wd, mem[7]);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rdata, er, addr, wdata; logic err, me, both, we; logic [2:0] f3; logic [8:0] wa;
    int edges, nrd, nwr, ee, en, ew, bad, idx;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom & 32'hFFFF_F81F;
      wdata = $urandom;
      idx = int'(addr[10:2]);
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: ready=%b want 1", i, req_ready);
      end
      model(we, f3, addr, wdata, er, me, ee, en, ew);
      do_req(we, f3, addr, wdata, rdata, err, edges, nrd, nwr, wa, both);
      checks++;
      if (rdata !== er || err !== me || edges != ee || nrd != en || nwr != ew || both ||
          mem[idx] !== ref_mem[idx] || (nwr != 0 && wa !== addr[10:2])) begin
        errors++;
        $display("FAIL rand[%0d] we=%b f3=%0d addr=%h: rdata=%h err=%b edges=%0d rd=%0d wr=%0d mem=%h want %h/%b/%0d/%0d/%0d/%h",
                 i, we, f3, addr, rdata, err, edges, nrd, nwr, mem[idx], er, me, ee, en, ew, ref_mem[idx]);
      end
    end
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mem_image: %0d words differ, want 0", bad);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 0; req_wdata = 0;
    resp_ready = 1'b1; reset = 1'b1;
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_loads();
    test_sw();
    test_subword();
    test_errors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
